// File: rtl/feature_map_repacker.sv
// feature_map_repacker
//   Takes one wide pixel word per Valid_In pulse from a conv layer (CH_IN channels of
//   DATA_WIDHT bits each) and buffers it in a small FIFO. Each word is then re-emitted as
//   R = CH_IN/CH_OUT narrower beats on a valid/ready stream, lowest channels first.
//   Last_Out flags the final beat of the last pixel of every IMG_WIDHT*IMG_HEIGHT frame.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   Data_In    pixel word, channel c at [DATA_WIDHT*c +: DATA_WIDHT]
//   Valid_In   Data_In is valid this cycle (upstream has no backpressure)
//   Ready_In   FIFO has room for a word (status only)
//   Data_Out   registered beat data (CH_OUT channels)
//   Valid_Out  beat valid
//   Ready_Out  downstream accepts the beat
//   Last_Out   with Valid_Out: last beat of the last pixel in the frame
//   Overflow   sticky flag, set when a Valid_In word had to be dropped
module feature_map_repacker #(
    parameter int DATA_WIDHT = 32,
    parameter int CH_IN      = 16,
    parameter int CH_OUT     = 8,
    parameter int DEPTH      = 16,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CH_IN-1:0]    Data_In,
    input  logic                           Valid_In,
    output logic                           Ready_In,
    output logic [DATA_WIDHT*CH_OUT-1:0]   Data_Out,
    output logic                           Valid_Out,
    input  logic                           Ready_Out,
    output logic                           Last_Out,
    output logic                           Overflow
);

    localparam int R  = CH_IN / CH_OUT;
    localparam int WW = DATA_WIDHT * CH_IN;
    localparam int BW = DATA_WIDHT * CH_OUT;
    localparam int P  = IMG_WIDHT * IMG_HEIGHT;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW = (R > 1) ? $clog2(R) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(R - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(P - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    state_t        state_next;

    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [KW-1:0] k;
    logic [KW-1:0] load_k;
    logic [PW-1:0] pix;
    logic [PW-1:0] pix_inc;
    logic [PW-1:0] load_pix;
    logic [WW-1:0] load_word;
    logic          load_en;
    logic          push;
    logic          pop;

    // The word being sliced stays at the FIFO head until its last beat is accepted,
    // so it still occupies a slot while it is being sent.
    assign Ready_In = (count < FULL);
    assign pop      = (state == SEND) && Ready_Out && (k == K_LAST);
    assign push     = Valid_In && (Ready_In || pop);
    assign pix_inc  = (pix == PIX_LAST) ? '0 : pix + PW'(1);

    // Decide which beat (if any) gets loaded into the output register on this edge.
    // After the last beat of a word, the next head is either the following FIFO entry
    // or, if the FIFO is about to run empty, the word arriving on this very edge.
    always_comb begin
        load_en   = 1'b0;
        load_k    = '0;
        load_pix  = pix;
        load_word = mem[rd_ptr];
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load_en = 1'b1;
                end
            end
            SEND: begin
                if (Ready_Out) begin
                    if (k != K_LAST) begin
                        load_en = 1'b1;
                        load_k  = k + KW'(1);
                    end else if (count > (AW + 1)'(1)) begin
                        load_en   = 1'b1;
                        load_word = mem[rd_ptr + AW'(1)];
                        load_pix  = pix_inc;
                    end else if (push) begin
                        load_en   = 1'b1;
                        load_word = Data_In;
                        load_pix  = pix_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = SEND;
            SEND:    if (pop && !load_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Valid_Out = (state == SEND);
    end

    // FIFO bookkeeping; a push and a pop on the same edge leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
            if (Valid_In && !push) Overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Data_In;
    end

    // Output beat register, beat index and frame pixel counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_Out <= '0;
            Last_Out <= 1'b0;
            k        <= '0;
            pix      <= '0;
        end else begin
            if (load_en) begin
                Data_Out <= load_word[BW*load_k +: BW];
                Last_Out <= (load_k == K_LAST) && (load_pix == PIX_LAST);
                k        <= load_k;
            end else if (pop) begin
                Last_Out <= 1'b0;
            end
            if (pop) pix <= pix_inc;
        end
    end

endmodule

// File: tb/tb_feature_map_repacker.sv
// tb_feature_map_repacker
//   Directed bench for feature_map_repacker with a 2x2 frame and a 4-deep FIFO.
//   dut  : CH_IN=16, CH_OUT=8 (two beats per word), checked by a beat scoreboard.
//   dut1 : CH_IN=16, CH_OUT=16 (one beat per word), fed the same input words.
module tb_feature_map_repacker;

    localparam int WW = 512;
    localparam int BW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] data_in;
    logic          valid_in;
    logic          ready_in;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          ready_out;
    logic          last_out;
    logic          overflow;

    logic          ready_in1;
    logic [WW-1:0] data_out1;
    logic          valid_out1;
    logic          ready_out1 = 1'b1;
    logic          last_out1;
    logic          overflow1;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    tests_run    = 0;
    int    tests_failed = 0;
    int    pix_idx      = 0;
    int    bursts       = 0;
    logic  prev_valid   = 1'b0;

    feature_map_repacker #(
        .DATA_WIDHT(32), .CH_IN(16), .CH_OUT(8), .DEPTH(4), .IMG_WIDHT(2), .IMG_HEIGHT(2)
    ) dut (
        .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in), .Ready_In(ready_in),
        .Data_Out(data_out), .Valid_Out(valid_out), .Ready_Out(ready_out),
        .Last_Out(last_out), .Overflow(overflow)
    );

    feature_map_repacker #(
        .DATA_WIDHT(32), .CH_IN(16), .CH_OUT(16), .DEPTH(4), .IMG_WIDHT(2), .IMG_HEIGHT(2)
    ) dut1 (
        .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in), .Ready_In(ready_in1),
        .Data_Out(data_out1), .Valid_Out(valid_out1), .Ready_Out(ready_out1),
        .Last_Out(last_out1), .Overflow(overflow1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WW-1:0] observed,
                               input logic [WW-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WW-1:0] makeWord(input logic [31:0] base);
        logic [WW-1:0] w;
        for (int c = 0; c < 16; c++) w[32*c +: 32] = base + 32'(c);
        return w;
    endfunction

    // Expected beats of an accepted word, with the frame-end flag from our own pixel count.
    task automatic pushExpected(input logic [WW-1:0] word);
        beat_t e;
        for (int b = 0; b < 2; b++) begin
            e.data = word[BW*b +: BW];
            e.last = (b == 1) && (pix_idx == 3);
            sb.push_back(e);
        end
        pix_idx = (pix_idx + 1) % 4;
    endtask

    // Drive one word for exactly one clock edge.
    task automatic applyStimulus(input logic [WW-1:0] word, input bit accepted);
        data_in  = word;
        valid_in = 1'b1;
        if (accepted) pushExpected(word);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            idleCycle();
            n++;
        end
        checkOutput({tag, "_drained"}, WW'(sb.size()), WW'(0));
        idleCycle();
        checkOutput({tag, "_idle"}, WW'(valid_out), WW'(0));
    endtask

    // Reset is asserted between edges; outputs must clear without waiting for a clock.
    task automatic resetDut(input string tag);
        rst = 1'b0;
        #1;
        checkOutput({tag, "_data_out"},  WW'(data_out),  WW'(0));
        checkOutput({tag, "_valid_out"}, WW'(valid_out), WW'(0));
        checkOutput({tag, "_last_out"},  WW'(last_out),  WW'(0));
        checkOutput({tag, "_overflow"},  WW'(overflow),  WW'(0));
        checkOutput({tag, "_ready_in"},  WW'(ready_in),  WW'(1));
        checkOutput({tag, "_valid_out1"}, WW'(valid_out1), WW'(0));
        sb.delete();
        pix_idx = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Beat monitor: every accepted beat must match the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_valid && !valid_out) bursts++;
            prev_valid = valid_out;
            if (valid_out && ready_out) begin : pop_blk
                beat_t e;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", WW'(valid_out), WW'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput("beat_data", WW'(data_out), WW'(e.data));
                    checkOutput("beat_last", WW'(last_out), WW'(e.last));
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WW-1:0] w;
        logic [WW-1:0] w0;
        int            b0;

        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        data_in   = '0;
        #2;

        // Single word: latency and beat split.
        resetDut("t1_rst");
        w = makeWord(32'h0000_0c00);
        applyStimulus(w, 1'b1);
        checkOutput("t1_valid_after_push", WW'(valid_out), WW'(0));
        idleCycle();
        checkOutput("t1_valid_rise", WW'(valid_out), WW'(1));
        checkOutput("t1_beat0", WW'(data_out), WW'(w[255:0]));
        checkOutput("t1_last0", WW'(last_out), WW'(0));
        idleCycle();
        checkOutput("t1_beat1", WW'(data_out), WW'(w[511:256]));
        checkOutput("t1_last1", WW'(last_out), WW'(0));
        waitDrain("t1", 20);

        // Two back-to-back frames, one word every two cycles: no bubbles between beats.
        resetDut("t2_rst");
        for (int f = 0; f < 2; f++) begin
            b0 = bursts;
            for (int i = 0; i < 4; i++) begin
                applyStimulus(makeWord(32'h0200_0000 + 32'(f*256 + i*16)), 1'b1);
                idleCycle();
            end
            waitDrain("t2_frame", 40);
            checkOutput("t2_one_burst", WW'(bursts - b0), WW'(1));
        end

        // Stall with a full FIFO, then overflow on the fifth word.
        resetDut("t3_rst");
        ready_out = 1'b0;
        w0 = makeWord(32'h0300_0000);
        applyStimulus(w0, 1'b1);
        for (int i = 1; i < 4; i++) applyStimulus(makeWord(32'h0300_0000 + 32'(i*16)), 1'b1);
        checkOutput("t3_ready_in_full", WW'(ready_in), WW'(0));
        checkOutput("t3_overflow_before", WW'(overflow), WW'(0));
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_stall_data", WW'(data_out), WW'(w0[255:0]));
            checkOutput("t3_stall_last", WW'(last_out), WW'(0));
            checkOutput("t3_stall_valid", WW'(valid_out), WW'(1));
            idleCycle();
        end
        applyStimulus(makeWord(32'h03ff_0000), 1'b0);
        checkOutput("t3_overflow_set", WW'(overflow), WW'(1));
        ready_out = 1'b1;
        waitDrain("t3", 40);
        checkOutput("t3_overflow_sticky", WW'(overflow), WW'(1));

        // Full FIFO: push coincides with the accept of beat 1, so nothing is dropped.
        resetDut("t4_rst");
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(makeWord(32'h0400_0000 + 32'(i*16)), 1'b1);
        ready_out = 1'b1;
        idleCycle();
        w = makeWord(32'h0400_0100);
        applyStimulus(w, 1'b1);
        w0 = makeWord(32'h0400_0010);
        checkOutput("t4_next_head", WW'(data_out), WW'(w0[255:0]));
        checkOutput("t4_still_full", WW'(ready_in), WW'(0));
        checkOutput("t4_no_overflow", WW'(overflow), WW'(0));
        waitDrain("t4", 40);
        checkOutput("t4_no_overflow_end", WW'(overflow), WW'(0));

        // Reset in the middle of a word, then a clean frame.
        resetDut("t5_pre");
        ready_out = 1'b0;
        w0 = makeWord(32'h0500_0000);
        applyStimulus(w0, 1'b1);
        applyStimulus(makeWord(32'h0500_0010), 1'b1);
        ready_out = 1'b1;
        idleCycle();
        ready_out = 1'b0;
        checkOutput("t5_at_beat1", WW'(data_out), WW'(w0[511:256]));
        resetDut("t5_mid");
        ready_out = 1'b1;
        b0 = bursts;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(makeWord(32'h0550_0000 + 32'(i*16)), 1'b1);
            idleCycle();
        end
        waitDrain("t5", 40);
        checkOutput("t5_one_burst", WW'(bursts - b0), WW'(1));

        // One-beat-per-word instance: pass-through with two-edge latency.
        resetDut("t6_rst");
        for (int i = 0; i < 4; i++) begin
            w = makeWord(32'h0600_0000 + 32'(i*16));
            applyStimulus(w, 1'b1);
            checkOutput("t6_valid_after_push", WW'(valid_out1), WW'(0));
            idleCycle();
            checkOutput("t6_valid", WW'(valid_out1), WW'(1));
            checkOutput("t6_data", data_out1, w);
            checkOutput("t6_last", WW'(last_out1), WW'(i == 3));
            idleCycle();
        end
        waitDrain("t6", 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
